// File: rtl/hid_multi_if.sv
// MCU byte-link bundle: strobed command/payload bytes in, one reply byte out.
interface hid_multi_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output data_in_strobe,
        output data_in_start,
        output data_in,
        input  data_out
    );

    modport slave (
        input  data_in_strobe,
        input  data_in_start,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/hid_multi.sv
// HID receiver: decodes MCU command packets into keyboard matrix, quadrature mouse,
// joysticks and a status readback. Optional wheel support via `define HID_WHEEL_EN.
module hid_multi #(
    parameter int KBD_ROWS = 15,
    parameter int NUM_JOY  = 2,
    parameter int MDIV_W   = 14,
    parameter int MACC_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hid_multi_if.slave            bus,
    output logic [5:0]            mouse,
    output logic [KBD_ROWS*8-1:0] keyboard,
`ifdef HID_WHEEL_EN
    output logic                  wheel_up,
    output logic                  wheel_down,
`endif
    output logic [NUM_JOY*8-1:0]  joystick
);
    localparam logic [7:0] CMD_STATUS = 8'd0;
    localparam logic [7:0] CMD_KEY    = 8'd1;
    localparam logic [7:0] CMD_MOUSE  = 8'd2;
    localparam logic [7:0] CMD_JOY    = 8'd3;
    localparam logic [7:0] CMD_KCLR   = 8'd4;
`ifdef HID_WHEEL_EN
    localparam logic WHEEL_EN = 1'b1;
`else
    localparam logic WHEEL_EN = 1'b0;
`endif
    localparam logic [7:0] STATUS3 = {3'(NUM_JOY - 1), WHEEL_EN, 4'(KBD_ROWS - 1)};

    typedef logic signed [MACC_W-1:0] acc_t;

    // Add a sign-extended byte with one guard bit; clamp instead of wrapping.
    function automatic acc_t sat_add(input acc_t a, input logic [7:0] d);
        logic [MACC_W:0] s;
        s = {a[MACC_W-1], a} + {{(MACC_W-7){d[7]}}, d};
        if (s[MACC_W] != s[MACC_W-1])
            return s[MACC_W] ? {1'b1, {(MACC_W-1){1'b0}}} : {1'b0, {(MACC_W-1){1'b1}}};
        return s[MACC_W-1:0];
    endfunction

    function automatic acc_t toward_zero(input acc_t a);
        return a[MACC_W-1] ? a + 1'b1 : a - 1'b1;
    endfunction

    // Positive motion walks 00->01->11->10, negative motion the reverse.
    function automatic logic [1:0] quad_step(input logic [1:0] q, input logic neg);
        return neg ? {~q[0], q[1]} : {q[0], ~q[1]};
    endfunction

    logic [7:0]               cmd_q, cmd_d;
    logic [3:0]               idx_q, idx_d;
    logic [7:0]               dout_q, dout_d;
    logic [KBD_ROWS-1:0][7:0] kbd_q, kbd_d;
    logic [NUM_JOY-1:0][7:0]  joy_q, joy_d;
    logic [7:0]               dev_q, dev_d;
    logic [1:0]               btn_q, btn_d;
    logic [1:0]               qx_q, qx_d, qy_q, qy_d;
    acc_t                     accx_q, accx_d, accy_q, accy_d;
    logic                     pendx_q, pendx_d, pendy_q, pendy_d;
    logic [MDIV_W-1:0]        div_q, div_d;
    logic                     tick, wr_x, wr_y;
`ifdef HID_WHEEL_EN
    acc_t                     accz_q, accz_d;
    logic                     pendz_q, pendz_d, wup_q, wup_d, wdn_q, wdn_d, wr_z;
`endif

    assign tick = &div_q;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no latch is inferred.
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        kbd_d   = kbd_q;
        joy_d   = joy_q;
        dev_d   = dev_q;
        btn_d   = btn_q;
        accx_d  = accx_q;
        accy_d  = accy_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        pendx_d = pendx_q;
        pendy_d = pendy_q;
        div_d   = div_q + 1'b1;
        wr_x    = 1'b0;
        wr_y    = 1'b0;
`ifdef HID_WHEEL_EN
        accz_d  = accz_q;
        pendz_d = pendz_q;
        wup_d   = 1'b0;
        wdn_d   = 1'b0;
        wr_z    = 1'b0;
`endif
        if (bus.data_in_strobe && bus.data_in_start) begin
            cmd_d = bus.data_in;
            idx_d = 4'd1;
            if (bus.data_in == CMD_KCLR)
                kbd_d = '1;
        end else if (bus.data_in_strobe && idx_q != 4'd0) begin
            if (idx_q != 4'hF)
                idx_d = idx_q + 1'b1;
            case (cmd_q)
                CMD_STATUS: begin
                    case (idx_q)
                        4'd1:    dout_d = 8'h5C;
                        4'd2:    dout_d = 8'h43;
                        4'd3:    dout_d = STATUS3;
                        default: dout_d = 8'h00;
                    endcase
                end
                CMD_KEY: begin
                    if (idx_q == 4'd1)
                        for (int r = 0; r < KBD_ROWS; r++)
                            if (bus.data_in[3:0] == 4'(r))
                                kbd_d[r][bus.data_in[6:4]] = bus.data_in[7];
                end
                CMD_MOUSE: begin
                    case (idx_q)
                        4'd1: btn_d = bus.data_in[1:0];
                        4'd2: begin accx_d = sat_add(accx_q, bus.data_in); wr_x = 1'b1; end
                        4'd3: begin accy_d = sat_add(accy_q, bus.data_in); wr_y = 1'b1; end
`ifdef HID_WHEEL_EN
                        4'd4: begin accz_d = sat_add(accz_q, bus.data_in); wr_z = 1'b1; end
`endif
                        default: ;
                    endcase
                end
                CMD_JOY: begin
                    if (idx_q == 4'd1)
                        dev_d = bus.data_in;
                    else if (idx_q == 4'd2)
                        for (int j = 0; j < NUM_JOY; j++)
                            if (dev_q == 8'(j))
                                joy_d[j] = bus.data_in;
                end
                default: ;
            endcase
        end

        // An accumulate beats a coincident tick; the pending flag replays that tick next cycle.
        if (wr_x) pendx_d = pendx_q | tick;
        else if (tick || pendx_q) begin
            pendx_d = 1'b0;
            if (accx_q != '0) begin
                accx_d = toward_zero(accx_q);
                qx_d   = quad_step(qx_q, accx_q[MACC_W-1]);
            end
        end
        if (wr_y) pendy_d = pendy_q | tick;
        else if (tick || pendy_q) begin
            pendy_d = 1'b0;
            if (accy_q != '0) begin
                accy_d = toward_zero(accy_q);
                qy_d   = quad_step(qy_q, accy_q[MACC_W-1]);
            end
        end
`ifdef HID_WHEEL_EN
        if (wr_z) pendz_d = pendz_q | tick;
        else if (tick || pendz_q) begin
            pendz_d = 1'b0;
            if (accz_q != '0) begin
                accz_d = toward_zero(accz_q);
                wup_d  = ~accz_q[MACC_W-1];
                wdn_d  = accz_q[MACC_W-1];
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            kbd_q   <= '1;
            joy_q   <= '0;
            dev_q   <= '0;
            btn_q   <= '0;
            accx_q  <= '0;
            accy_q  <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            pendx_q <= 1'b0;
            pendy_q <= 1'b0;
            div_q   <= '0;
`ifdef HID_WHEEL_EN
            accz_q  <= '0;
            pendz_q <= 1'b0;
            wup_q   <= 1'b0;
            wdn_q   <= 1'b0;
`endif
        end else begin
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            kbd_q   <= kbd_d;
            joy_q   <= joy_d;
            dev_q   <= dev_d;
            btn_q   <= btn_d;
            accx_q  <= accx_d;
            accy_q  <= accy_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            pendx_q <= pendx_d;
            pendy_q <= pendy_d;
            div_q   <= div_d;
`ifdef HID_WHEEL_EN
            accz_q  <= accz_d;
            pendz_q <= pendz_d;
            wup_q   <= wup_d;
            wdn_q   <= wdn_d;
`endif
        end
    end

    assign bus.data_out = dout_q;
    assign mouse        = {btn_q, qx_q, qy_q};
    assign keyboard     = kbd_q;
    assign joystick     = joy_q;
`ifdef HID_WHEEL_EN
    assign wheel_up     = wup_q;
    assign wheel_down   = wdn_q;
`endif
endmodule

// File: tb/tb_hid_multi.sv
// Directed bench for hid_multi (default parameters, MDIV_W=4): status, keys, joystick,
// mouse quadrature drain, saturation and reset mid-packet.
module tb_hid_multi;
    localparam int KBD_ROWS = 15;
    localparam int NUM_JOY  = 2;
    localparam int MDIV_W   = 4;
    localparam int MACC_W   = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [5:0]            mouse;
    logic [KBD_ROWS*8-1:0] keyboard;
    logic [NUM_JOY*8-1:0]  joystick;
`ifdef HID_WHEEL_EN
    logic                  wheel_up, wheel_down;
`endif
    int errors = 0;
    int checks = 0;

    hid_multi_if bus ();

    hid_multi #(
        .KBD_ROWS(KBD_ROWS), .NUM_JOY(NUM_JOY), .MDIV_W(MDIV_W), .MACC_W(MACC_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .mouse(mouse),
        .keyboard(keyboard),
`ifdef HID_WHEEL_EN
        .wheel_up(wheel_up),
        .wheel_down(wheel_down),
`endif
        .joystick(joystick)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
        bus.data_in        = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send(input logic start, input logic [7:0] d);
        @(posedge clk); #1;
        bus.data_in_strobe = 1'b1;
        bus.data_in_start  = start;
        bus.data_in        = d;
        @(posedge clk); #1;
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
    endtask

    // Expected next quadrature state, written out as the documented sequence table.
    function automatic logic [1:0] next_q(input logic [1:0] q, input logic fwd);
        if (fwd)
            case (q) 2'b00: return 2'b01; 2'b01: return 2'b11; 2'b11: return 2'b10; default: return 2'b00; endcase
        else
            case (q) 2'b00: return 2'b10; 2'b10: return 2'b11; 2'b11: return 2'b01; default: return 2'b00; endcase
    endfunction

    // Watch the quadrature outputs for a fixed window, counting steps and out-of-order moves.
    task automatic watch(input int cycles, input logic x_fwd, input logic y_fwd,
                         output int nx, output int ny, output int bad, output int first_x);
        logic [1:0] px, py;
        nx = 0; ny = 0; bad = 0; first_x = -1;
        @(negedge clk);
        px = mouse[3:2]; py = mouse[1:0];
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (mouse[3:2] != px) begin
                if (mouse[3:2] != next_q(px, x_fwd)) bad++;
                if (first_x < 0) first_x = c;
                nx++; px = mouse[3:2];
            end
            if (mouse[1:0] != py) begin
                if (mouse[1:0] != next_q(py, y_fwd)) bad++;
                ny++; py = mouse[1:0];
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (keyboard !== '1) begin errors++; $display("FAIL reset_kbd got=%h want=all ones", keyboard); end
        checks++; if (joystick !== '0) begin errors++; $display("FAIL reset_joy got=%h want=0", joystick); end
        checks++; if (mouse !== 6'd0) begin errors++; $display("FAIL reset_mouse got=%b want=000000", mouse); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", bus.data_out); end
    endtask

    task automatic test_status();
        logic [7:0] exp [4] = '{8'h5C, 8'h43, 8'h2E, 8'h00};
        // Bytes before any start are ignored.
        send(1'b0, 8'h11);
        @(negedge clk);
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL status_prestart got=%h want=00", bus.data_out); end
        send(1'b1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 8'hFF);
            @(negedge clk);
            checks++;
            if (bus.data_out !== exp[k]) begin errors++; $display("FAIL status_k%0d got=%h want=%h", k + 1, bus.data_out, exp[k]); end
        end
        // Unknown command leaves data_out alone.
        send(1'b1, 8'h07);
        send(1'b0, 8'h55);
        @(negedge clk);
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL status_unknown got=%h want=00", bus.data_out); end
    endtask

    task automatic test_key();
        logic [KBD_ROWS*8-1:0] exp;
        exp = '1; exp[5*8+2] = 1'b0;
        send(1'b1, 8'h01); send(1'b0, 8'h25);
        @(negedge clk);
        checks++; if (keyboard !== exp) begin errors++; $display("FAIL key_press got=%h want=%h", keyboard, exp); end
        send(1'b0, 8'hA5);   // further bytes of the packet are ignored
        @(negedge clk);
        checks++; if (keyboard !== exp) begin errors++; $display("FAIL key_extra got=%h want=%h", keyboard, exp); end
        send(1'b1, 8'h01); send(1'b0, 8'hA5);
        @(negedge clk);
        checks++; if (keyboard !== '1) begin errors++; $display("FAIL key_release got=%h want=all ones", keyboard); end
        send(1'b1, 8'h01); send(1'b0, 8'h0F);
        @(negedge clk);
        checks++; if (keyboard !== '1) begin errors++; $display("FAIL key_row15 got=%h want=all ones", keyboard); end
        exp = '1; exp[14*8+0] = 1'b0;
        send(1'b1, 8'h01); send(1'b0, 8'h0E);
        @(negedge clk);
        checks++; if (keyboard !== exp) begin errors++; $display("FAIL key_row14 got=%h want=%h", keyboard, exp); end
        send(1'b1, 8'h04);
        @(negedge clk);
        checks++; if (keyboard !== '1) begin errors++; $display("FAIL key_clear got=%h want=all ones", keyboard); end
    endtask

    task automatic test_joystick();
        send(1'b1, 8'h03); send(1'b0, 8'h01); send(1'b0, 8'h5A);
        @(negedge clk);
        checks++; if (joystick !== 16'h5A00) begin errors++; $display("FAIL joy_set got=%h want=5a00", joystick); end
        send(1'b1, 8'h03); send(1'b0, 8'h00); send(1'b0, 8'hC3);
        @(negedge clk);
        checks++; if (joystick !== 16'h5AC3) begin errors++; $display("FAIL joy_dev0 got=%h want=5ac3", joystick); end
        send(1'b1, 8'h03); send(1'b0, 8'h09); send(1'b0, 8'hFF);
        @(negedge clk);
        checks++; if (joystick !== 16'h5AC3) begin errors++; $display("FAIL joy_dev9 got=%h want=5ac3", joystick); end
    endtask

    task automatic test_mouse();
        int nx, ny, bad, first_x;
        do_reset();
        send(1'b1, 8'h02); send(1'b0, 8'h00); send(1'b0, 8'h03); send(1'b0, 8'hFE);
        watch(200, 1'b1, 1'b0, nx, ny, bad, first_x);
        checks++; if (nx !== 3) begin errors++; $display("FAIL mouse_xsteps got=%0d want=3", nx); end
        checks++; if (ny !== 2) begin errors++; $display("FAIL mouse_ysteps got=%0d want=2", ny); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mouse_order got=%0d want=0 bad steps", bad); end
        checks++; if (mouse !== 6'b00_10_11) begin errors++; $display("FAIL mouse_final got=%b want=001011", mouse); end
        checks++;
        if (first_x < 1 || first_x + 1 > (1 << MDIV_W) + 1) begin
            errors++; $display("FAIL mouse_latency got=%0d want<=%0d", first_x + 1, (1 << MDIV_W) + 1);
        end
    endtask

    task automatic test_saturation();
        int nx, ny, bad, first_x;
        do_reset();
        send(1'b1, 8'h02); send(1'b0, 8'h00); send(1'b0, 8'h70);
        send(1'b1, 8'h02); send(1'b0, 8'h00); send(1'b0, 8'h70);
        watch(127 * (1 << MDIV_W) + 100, 1'b1, 1'b1, nx, ny, bad, first_x);
        checks++; if (nx !== 127) begin errors++; $display("FAIL sat_xsteps got=%0d want=127", nx); end
        checks++; if (ny !== 0) begin errors++; $display("FAIL sat_ysteps got=%0d want=0", ny); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sat_order got=%0d want=0 bad steps", bad); end
        checks++; if (mouse[3:2] !== 2'b10) begin errors++; $display("FAIL sat_final got=%b want=10", mouse[3:2]); end
    endtask

    task automatic test_reset_mid_packet();
        send(1'b1, 8'h01); send(1'b0, 8'h25);
        send(1'b1, 8'h03); send(1'b0, 8'h00); send(1'b0, 8'h77);
        send(1'b1, 8'h02); send(1'b0, 8'h03);
        @(negedge clk);
        checks++; if (mouse[5:4] !== 2'b11) begin errors++; $display("FAIL mid_btn got=%b want=11", mouse[5:4]); end
        do_reset();
        @(negedge clk);
        checks++; if (mouse !== 6'd0) begin errors++; $display("FAIL mid_mouse got=%b want=000000", mouse); end
        checks++; if (keyboard !== '1) begin errors++; $display("FAIL mid_kbd got=%h want=all ones", keyboard); end
        checks++; if (joystick !== '0) begin errors++; $display("FAIL mid_joy got=%h want=0", joystick); end
        send(1'b0, 8'h05);
        repeat (3 * (1 << MDIV_W)) @(negedge clk);
        checks++; if (mouse !== 6'd0) begin errors++; $display("FAIL mid_ignored got=%b want=000000", mouse); end
        // The parser resumes on the next start.
        send(1'b1, 8'h02); send(1'b0, 8'h02);
        @(negedge clk);
        checks++; if (mouse !== 6'b10_00_00) begin errors++; $display("FAIL mid_resume got=%b want=100000", mouse); end
    endtask

    initial begin
        bus.data_in_strobe = 1'b0;
        bus.data_in_start  = 1'b0;
        bus.data_in        = 8'h00;
        test_reset();
        test_status();
        test_key();
        test_joystick();
        test_mouse();
        test_saturation();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
